gray_mem_arb: RTL and testbench

Two-requester arbiter for the single-port 16K x 8 grayscale image SRAM. Requester 0 is the host loader, which writes a new 128x128 frame and may read it back. Requester 1 is the LBP engine's gray-pixel fetch port. The block grants one access per cycle and holds ownership for bounded bursts, so the engine's 3x3 window fetches stay contiguous. It also supports a host exclusive lock during frame load and routes synchronous read data back to the requester that issued the read.

---
 rtl/gray_mem_pkg.sv | 16 +
 rtl/arb_rr2.sv | 47 ++++
 rtl/gray_mem_arb.sv | 111 +++++++++++
 tb/tb_gray_mem_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_mem_pkg.sv
// Shared types and constants for the grayscale image SRAM arbiter.
// Sized for a 128x128 frame of 8-bit pixels.
package gray_mem_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 8;
    localparam int IMG_W      = 128;
    localparam int IMG_PIXELS = IMG_W * IMG_W;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick with burst hold and m1 lock masking.
// Purely combinational; returns the candidate owner for this cycle.
module arb_rr2
    import gray_mem_pkg::*;
#(
    parameter int MAX_BURST = 9
) (
    input  logic       en,
    input  logic       req0,
    input  logic       req1,
    input  logic       lock,
    input  logic [1:0] owner,
    input  logic [1:0] last,
    input  logic [3:0] burst_cnt,
    output logic [1:0] cand
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic req1_eff;
    logic hold_ok;
    owner_t pick;

    assign req1_eff = req1 & ~lock;
    assign hold_ok  = (burst_cnt < BURST_MAX);

    // Hold for the current owner wins before the round-robin tie-break.
    always_comb begin
        pick = OWN_NONE;
        if (!en) begin
            pick = OWN_NONE;
        end else if (owner == OWN_M0 && req0 && hold_ok) begin
            pick = OWN_M0;
        end else if (owner == OWN_M1 && req1_eff && hold_ok) begin
            pick = OWN_M1;
        end else if (req0 && req1_eff) begin
            pick = (last == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (req0) begin
            pick = OWN_M0;
        end else if (req1_eff) begin
            pick = OWN_M1;
        end
    end

    assign cand = pick;

endmodule

// File: rtl/gray_mem_arb.sv
// Host/LBP arbiter for the single-port 16K x 8 gray image SRAM.
// Holds owner, burst count, last winner and read-return tag; muxes SRAM signals.
module gray_mem_arb
    import gray_mem_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic       arb_en;
    owner_t     owner;
    owner_t     last;
    owner_t     rtag;
    logic [3:0] burst_cnt;
    logic [1:0] cand_bits;
    owner_t     cand;
    logic       cand_rd;

    arb_rr2 #(.MAX_BURST(MAX_BURST)) u_arb (
        .en        (arb_en),
        .req0      (m0_req),
        .req1      (m1_req),
        .lock      (m0_lock),
        .owner     (owner),
        .last      (last),
        .burst_cnt (burst_cnt),
        .cand      (cand_bits)
    );

    assign cand = owner_t'(cand_bits);

    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cand_rd   = 1'b0;
        case (cand)
            OWN_M0: begin
                m0_gnt    = 1'b1;
                mem_cs    = 1'b1;
                mem_we    = m0_we;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                cand_rd   = ~m0_we;
            end
            OWN_M1: begin
                m1_gnt   = 1'b1;
                mem_cs   = 1'b1;
                mem_addr = m1_addr;
                cand_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    // Saturating count lets a solo owner stream forever yet yield at once when the other side asks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_en    <= 1'b0;
            owner     <= OWN_NONE;
            last      <= OWN_M1;
            rtag      <= OWN_NONE;
            burst_cnt <= '0;
        end else begin
            arb_en <= 1'b1;
            owner  <= cand;
            rtag   <= cand_rd ? cand : OWN_NONE;
            if (cand == OWN_NONE) begin
                burst_cnt <= '0;
            end else if (cand == owner) begin
                burst_cnt <= (burst_cnt >= BURST_MAX) ? BURST_MAX : burst_cnt + 4'd1;
            end else begin
                burst_cnt <= 4'd1;
            end
            if (cand != OWN_NONE) begin
                last <= cand;
            end
        end
    end

    assign m0_rvalid = (rtag == OWN_M0);
    assign m1_rvalid = (rtag == OWN_M1);
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_gray_mem_arb.sv
// Scoreboard bench for gray_mem_arb: rule-level arbitration model, SRAM model,
// read-return queue checked by an independent monitor.
module tb_gray_mem_arb;
    import gray_mem_pkg::*;

    localparam int AW = 14;
    localparam int DW = 8;
    localparam int MB = 9;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0, m0_lock = 1'b0, m1_req = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic          mem_cs, mem_we;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    gray_mem_arb #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .rdata(rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural synchronous SRAM.
    logic [DW-1:0] sram [IMG_PIXELS];
    logic [DW-1:0] sram_q = '0;
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        sram_q <= sram[mem_addr];
        end
    end
    assign mem_rdata = sram_q;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
    } rd_t;
    rd_t sbq[$];

    // Reference model state: owner/last as 0=none,1=m0,2=m1.
    logic [DW-1:0] ref_mem [IMG_PIXELS];
    int m_en, m_owner, m_cnt, m_last, e_cand;
    bit mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        bit r0, r1;
        r0 = m0_req;
        r1 = m1_req && !m0_lock;
        if (m_en == 0) return 0;
        if (m_owner == 1 && r0 && m_cnt < MB) return 1;
        if (m_owner == 2 && r1 && m_cnt < MB) return 2;
        if (r0 && r1) return 3 - m_last;
        if (r0) return 1;
        if (r1) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_en = 0; m_owner = 0; m_cnt = 0; m_last = 2;
        sbq.delete();
    endtask

    task automatic check_comb();
        logic [AW-1:0] ea;
        e_cand = pick();
        ea = (e_cand == 1) ? m0_addr : (e_cand == 2) ? m1_addr : '0;
        chk("m0_gnt", 32'(m0_gnt), 32'(e_cand == 1));
        chk("m1_gnt", 32'(m1_gnt), 32'(e_cand == 2));
        chk("mem_cs", 32'(mem_cs), 32'(e_cand != 0));
        chk("mem_we", 32'(mem_we), 32'(e_cand == 1 && m0_we));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (e_cand != 2) chk("mem_wdata", 32'(mem_wdata), (e_cand == 1) ? 32'(m0_wdata) : 32'd0);
        chk("rdata_pass", 32'(rdata), 32'(mem_rdata));
        if (e_cand == 2 || (e_cand == 1 && !m0_we))
            sbq.push_back('{who: e_cand, data: ref_mem[ea]});
    endtask

    task automatic update_model();
        if (!rst_n) return;
        if (m_en == 0) begin
            m_en = 1;
            return;
        end
        if (e_cand == 0)            m_cnt = 0;
        else if (e_cand == m_owner) m_cnt = (m_cnt + 1 > MB) ? MB : m_cnt + 1;
        else                        m_cnt = 1;
        m_owner = e_cand;
        if (e_cand != 0) m_last = e_cand;
        if (e_cand == 1 && m0_we) ref_mem[m0_addr] = m0_wdata;
    endtask

    task automatic tick();
        #1 check_comb();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic drive(input bit r0, input bit we, input int a0, input int wd,
                         input bit lk, input bit r1, input int a1);
        m0_req = r0; m0_we = we; m0_addr = AW'(a0); m0_wdata = DW'(wd);
        m0_lock = lk; m1_req = r1; m1_addr = AW'(a1);
    endtask

    // Monitor: every cycle, the oldest outstanding read must return now on the right port.
    always @(negedge clk) begin
        if (mon_on) begin
            if (sbq.size() > 0) begin
                rd_t e;
                e = sbq.pop_front();
                chk("rvalid_route", {30'd0, m1_rvalid, m0_rvalid}, (e.who == 2) ? 32'd2 : 32'd1);
                chk("rdata", 32'(rdata), 32'(e.data));
            end else begin
                chk("rvalid_idle", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
            end
        end
    end

    initial begin
        for (int i = 0; i < IMG_PIXELS; i++) begin
            sram[i] = DW'($urandom);
            ref_mem[i] = sram[i];
        end
        sram[14'h0081] = 8'h5A; ref_mem[14'h0081] = 8'h5A;
        sram[14'h0000] = 8'h11; ref_mem[14'h0000] = 8'h11;
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge clk);
        mon_on = 1'b1;

        // Requests held through reset: nothing granted until the first edge after release.
        drive(1, 0, 5, 0, 0, 1, 6);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Contention: both requesters stream reads.
        for (int i = 0; i < 40; i++) begin
            drive(1, 0, 100 + i, 0, 0, 1, 200 + i);
            tick();
        end

        // Solo m1, then m0 arrives with m1's count saturated.
        for (int i = 0; i < 30; i++) begin
            drive(0, 0, 0, 0, 0, 1, 300 + i);
            tick();
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 400 + i, 0, 0, 1, 300 + i);
            tick();
        end

        // Read routing back-to-back across an owner switch.
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1, 'h0081);
        tick();
        drive(1, 0, 'h0000, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Lock preempts an m1 burst; the in-flight m1 read still returns.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 500 + i);
            tick();
        end
        drive(1, 1, 'h1234, 'hFF, 1, 1, 503);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 1, 1, 504 + i);
            tick();
        end
        drive(1, 0, 'h1234, 0, 0, 1, 510);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 1, 511 + i);
            tick();
        end

        // Async reset between an m1 read grant and its return.
        drive(0, 0, 0, 0, 0, 1, 'h0081);
        #1 check_comb();
        @(posedge clk);
        update_model();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic with occasional locks.
        for (int i = 0; i < 1500; i++) begin
            drive(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0),
                  int'($urandom_range(0, 63)), int'($urandom),
                  1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, 63)));
            tick();
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
